cci_mpf_vtp_csr_ctrl: RTL and testbench

CCI_MPF_VTP_CSR_CTRL -- requirements
Module: cci_mpf_vtp_csr_ctrl

---
 rtl/cci_mpf_vtp_csr_ctrl.sv | 126 ++++++++++++
 tb/tb_cci_mpf_vtp_csr_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_vtp_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_vtp_csr_ctrl
// Brief    : VTP CSR block: mode / page-table base registers, event counters,
//            and a two-stage MMIO read response pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_vtp_csr_ctrl #(
    parameter int  N_EVENTS  = 7,
    parameter int  CNT_WIDTH = 64,
    parameter type t_cci_mpf_vtp_csr_mode = logic [3:0],
    parameter type t_cci_clAddr           = logic [41:0]
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [3:0]            wr_idx,
    input  logic [63:0]           wr_data,
    input  logic                  rd_valid,
    input  logic [3:0]            rd_idx,
    input  logic [8:0]            rd_tid,
    output logic                  rsp_valid,
    output logic [8:0]            rsp_tid,
    output logic [63:0]           rsp_data,
    input  logic [N_EVENTS-1:0]   events,
    output t_cci_mpf_vtp_csr_mode vtp_mode,
    output t_cci_clAddr           vtp_pt_base,
    output logic                  vtp_pt_base_valid
);

    localparam int c_MODE_W  = $bits(t_cci_mpf_vtp_csr_mode);
    localparam int c_BASE_W  = $bits(t_cci_clAddr);
    localparam logic [3:0] c_IDX_MODE = 4'd0;
    localparam logic [3:0] c_IDX_BASE = 4'd1;
    localparam logic [3:0] c_IDX_CTRL = 4'd9;

    logic [CNT_WIDTH-1:0] r_cnt [N_EVENTS];
    logic [N_EVENTS-1:0]  w_clr;
    logic                 w_ctrl_clr;
    logic [63:0]          w_rd_data;

    logic                 r_s1_valid;
    logic [8:0]           r_s1_tid;
    logic [63:0]          r_s1_data;

    // Upper write-data bits beyond the page-table base have no destination.
    generate
        if (c_BASE_W < 64) begin : g_unused_wr
            logic w_unused;
            assign w_unused = ^wr_data[63:c_BASE_W];
        end
    endgenerate

    assign w_ctrl_clr = wr_valid && (wr_idx == c_IDX_CTRL) && wr_data[0];

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            w_clr[i] = w_ctrl_clr || (wr_valid && (wr_idx == 4'(i + 2)));
        end
    end

    // A clear wins over a same-cycle event; counters wrap naturally.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_EVENTS; i++) begin
            if (reset || w_clr[i]) begin
                r_cnt[i] <= '0;
            end else if (events[i]) begin
                r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vtp_mode          <= '0;
            vtp_pt_base       <= '0;
            vtp_pt_base_valid <= 1'b0;
        end else if (wr_valid) begin
            if (wr_idx == c_IDX_MODE) begin
                vtp_mode <= t_cci_mpf_vtp_csr_mode'(wr_data[c_MODE_W-1:0]);
            end
            if (wr_idx == c_IDX_BASE) begin
                vtp_pt_base       <= t_cci_clAddr'(wr_data[c_BASE_W-1:0]);
                vtp_pt_base_valid <= 1'b1;
            end
        end
    end

    // Read data comes from register state at the start of the request cycle.
    always_comb begin
        w_rd_data = '0;
        if (rd_idx == c_IDX_MODE) begin
            w_rd_data = 64'(vtp_mode);
        end else if (rd_idx == c_IDX_BASE) begin
            w_rd_data = 64'(vtp_pt_base);
        end else begin
            for (int i = 0; i < N_EVENTS; i++) begin
                if (rd_idx == 4'(i + 2)) begin
                    w_rd_data = 64'(r_cnt[i]);
                end
            end
        end
    end

    // Idle slots carry zeros so the response bus is quiet when not valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_tid   <= '0;
            r_s1_data  <= '0;
            rsp_valid  <= 1'b0;
            rsp_tid    <= '0;
            rsp_data   <= '0;
        end else begin
            r_s1_valid <= rd_valid;
            r_s1_tid   <= rd_valid ? rd_tid : 9'd0;
            r_s1_data  <= rd_valid ? w_rd_data : 64'd0;
            rsp_valid  <= r_s1_valid;
            rsp_tid    <= r_s1_tid;
            rsp_data   <= r_s1_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_vtp_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_vtp_csr_ctrl
// Brief    : Self-checking bench for cci_mpf_vtp_csr_ctrl with a CSR-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_vtp_csr_ctrl;

    localparam int MODE_W = 4;
    localparam int BASE_W = 42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              wr_valid;
    logic [3:0]        wr_idx;
    logic [63:0]       wr_data;
    logic              rd_valid;
    logic [3:0]        rd_idx;
    logic [8:0]        rd_tid;
    logic              rsp_valid;
    logic [8:0]        rsp_tid;
    logic [63:0]       rsp_data;
    logic [6:0]        events;
    logic [MODE_W-1:0] vtp_mode;
    logic [BASE_W-1:0] vtp_pt_base;
    logic              vtp_pt_base_valid;

    logic              n_rd_valid;
    logic [3:0]        n_rd_idx;
    logic [8:0]        n_rd_tid;
    logic              n_rsp_valid;
    logic [8:0]        n_rsp_tid;
    logic [63:0]       n_rsp_data;
    logic [6:0]        n_events;
    logic [MODE_W-1:0] n_vtp_mode;
    logic [BASE_W-1:0] n_vtp_pt_base;
    logic              n_vtp_pt_base_valid;

    cci_mpf_vtp_csr_ctrl dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_tid(rd_tid),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .events(events),
        .vtp_mode(vtp_mode), .vtp_pt_base(vtp_pt_base),
        .vtp_pt_base_valid(vtp_pt_base_valid)
    );

    // Narrow-counter instance makes the wrap boundary reachable in a few cycles.
    cci_mpf_vtp_csr_ctrl #(.CNT_WIDTH(8)) dut_narrow (
        .clk(clk), .reset(reset),
        .wr_valid(1'b0), .wr_idx(4'd0), .wr_data(64'd0),
        .rd_valid(n_rd_valid), .rd_idx(n_rd_idx), .rd_tid(n_rd_tid),
        .rsp_valid(n_rsp_valid), .rsp_tid(n_rsp_tid), .rsp_data(n_rsp_data),
        .events(n_events),
        .vtp_mode(n_vtp_mode), .vtp_pt_base(n_vtp_pt_base),
        .vtp_pt_base_valid(n_vtp_pt_base_valid)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    logic [63:0] m_cnt [7];
    logic [63:0] m_mode;
    logic [63:0] m_base;
    logic        m_valid;

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
    } exp_t;

    function automatic logic [63:0] m_read(input logic [3:0] idx);
        if (idx == 4'd0) return m_mode;
        if (idx == 4'd1) return m_base;
        if (idx >= 4'd2 && idx <= 4'd8) return m_cnt[idx - 4'd2];
        return 64'd0;
    endfunction

    // Apply this cycle's inputs to the model, then advance one clock.
    task automatic step();
        logic clr_all;
        logic clr;
        clr_all = wr_valid && (wr_idx == 4'd9) && wr_data[0];
        if (reset) begin
            for (int i = 0; i < 7; i++) m_cnt[i] = 64'd0;
            m_mode  = 64'd0;
            m_base  = 64'd0;
            m_valid = 1'b0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                clr = clr_all || (wr_valid && (int'(wr_idx) == i + 2));
                if (clr) m_cnt[i] = 64'd0;
                else if (events[i]) m_cnt[i] = m_cnt[i] + 64'd1;
            end
            if (wr_valid && wr_idx == 4'd0) m_mode = wr_data & ((64'd1 << MODE_W) - 64'd1);
            if (wr_valid && wr_idx == 4'd1) begin
                m_base  = wr_data & ((64'd1 << BASE_W) - 64'd1);
                m_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_idx = 4'd0; wr_data = 64'd0;
        rd_valid = 1'b0; rd_idx = 4'd0; rd_tid = 9'd0;
        events = 7'd0;
        n_rd_valid = 1'b0; n_rd_idx = 4'd0; n_rd_tid = 9'd0; n_events = 7'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_valid = 1'b1; wr_idx = 4'd1; wr_data = {$urandom, $urandom};
        rd_valid = 1'b1; rd_idx = 4'd1; rd_tid = 9'h1AB;
        events = 7'h7F; n_events = 7'h7F;
        step();
        step();
        chk_cnt++; if (vtp_mode !== '0) $display("FAIL reset_mode: got %h want 0", vtp_mode); else pass_cnt++;
        chk_cnt++; if (vtp_pt_base !== '0) $display("FAIL reset_base: got %h want 0", vtp_pt_base); else pass_cnt++;
        chk_cnt++; if (vtp_pt_base_valid !== 1'b0) $display("FAIL reset_base_valid: got %b want 0", vtp_pt_base_valid); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0 || rsp_tid !== 9'd0 || rsp_data !== 64'd0)
            $display("FAIL reset_rsp: got v=%b tid=%h data=%h want all 0", rsp_valid, rsp_tid, rsp_data);
        else pass_cnt++;
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rd_ignored: got rsp_valid=%b want 0", rsp_valid); else pass_cnt++;
        rd_valid = 1'b1; rd_idx = 4'd2; rd_tid = 9'd1;
        step();
        rd_valid = 1'b0;
        step();
        chk_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd0)
            $display("FAIL reset_cnt0: got v=%b data=%h want v=1 data=0", rsp_valid, rsp_data);
        else pass_cnt++;
    endtask

    task automatic test_csr_write();
        logic [63:0] exp;
        wr_valid = 1'b1; wr_idx = 4'd1; wr_data = 64'h1234;
        step();
        wr_valid = 1'b0;
        chk_cnt++; if (vtp_pt_base !== 42'h1234 || vtp_pt_base_valid !== 1'b1)
            $display("FAIL pt_base_write: got %h/%b want 1234/1", vtp_pt_base, vtp_pt_base_valid);
        else pass_cnt++;
        wr_valid = 1'b1; wr_idx = 4'd0; wr_data = {$urandom, $urandom} | 64'h5;
        step();
        wr_valid = 1'b0;
        chk_cnt++; if (vtp_mode !== m_mode[MODE_W-1:0]) $display("FAIL mode_write: got %h want %h", vtp_mode, m_mode[MODE_W-1:0]); else pass_cnt++;
        wr_valid = 1'b1; wr_idx = 4'd12; wr_data = {$urandom, $urandom};
        step();
        wr_idx = 4'd9; wr_data = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        wr_valid = 1'b0;
        chk_cnt++; if (vtp_mode !== m_mode[MODE_W-1:0] || vtp_pt_base !== 42'h1234)
            $display("FAIL reserved_write: got mode=%h base=%h want %h/1234", vtp_mode, vtp_pt_base, m_mode[MODE_W-1:0]);
        else pass_cnt++;
        rd_valid = 1'b1; rd_idx = 4'd1; rd_tid = 9'd5;
        step();
        rd_valid = 1'b0; rd_tid = 9'd0;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rd_latency_early: got rsp_valid=%b want 0", rsp_valid); else pass_cnt++;
        step();
        chk_cnt++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'd5 || rsp_data !== 64'h1234)
            $display("FAIL rd_pt_base: got v=%b tid=%0d data=%h want 1/5/1234", rsp_valid, rsp_tid, rsp_data);
        else pass_cnt++;
        step();
        chk_cnt++; if (rsp_valid !== 1'b0 || rsp_tid !== 9'd0 || rsp_data !== 64'd0)
            $display("FAIL rd_single_pulse: got v=%b tid=%h data=%h want 0", rsp_valid, rsp_tid, rsp_data);
        else pass_cnt++;
        rd_valid = 1'b1; rd_idx = 4'd0; rd_tid = 9'd6;
        exp = m_read(4'd0);
        step();
        rd_valid = 1'b0;
        step();
        chk_cnt++; if (rsp_data !== exp || rsp_data[63:MODE_W] !== '0)
            $display("FAIL rd_mode: got %h want %h", rsp_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_events();
        logic [63:0] old;
        events = 7'b0000100;
        for (int i = 0; i < 10; i++) step();
        events = 7'd0;
        rd_valid = 1'b1; rd_idx = 4'd4; rd_tid = 9'd7;
        step();
        rd_valid = 1'b0;
        step();
        chk_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd10)
            $display("FAIL event_count10: got v=%b data=%0d want 1/10", rsp_valid, rsp_data);
        else pass_cnt++;
        old = m_read(4'd2);
        events = 7'b0000001; rd_valid = 1'b1; rd_idx = 4'd2; rd_tid = 9'd8;
        step();
        events = 7'd0;
        step();
        chk_cnt++; if (rsp_data !== old) $display("FAIL event_same_cycle_read: got %0d want %0d", rsp_data, old); else pass_cnt++;
        step();
        rd_valid = 1'b0;
        chk_cnt++; if (rsp_data !== old + 64'd1) $display("FAIL event_next_read: got %0d want %0d", rsp_data, old + 64'd1); else pass_cnt++;
        step();
    endtask

    task automatic test_clear();
        logic [63:0] exp [7];
        events = 7'b0000010;
        for (int i = 0; i < 3; i++) step();
        wr_valid = 1'b1; wr_idx = 4'd3; wr_data = {$urandom, $urandom};
        step();
        wr_valid = 1'b0; events = 7'd0;
        rd_valid = 1'b1; rd_idx = 4'd3; rd_tid = 9'd9;
        step();
        rd_valid = 1'b0;
        step();
        chk_cnt++; if (rsp_data !== 64'd0 || m_cnt[1] !== 64'd0)
            $display("FAIL clear_beats_event: got %0d want 0", rsp_data);
        else pass_cnt++;
        events = 7'h7F;
        for (int i = 0; i < 4; i++) step();
        events = 7'd0;
        wr_valid = 1'b1; wr_idx = 4'd9; wr_data = 64'h2;
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_idx = 4'd5; rd_tid = 9'd10;
        step();
        rd_valid = 1'b0;
        step();
        chk_cnt++; if (rsp_data !== 64'd4) $display("FAIL ctrl_bit0_zero: got %0d want 4", rsp_data); else pass_cnt++;
        wr_valid = 1'b1; wr_idx = 4'd9; wr_data = 64'h1; events = 7'h7F;
        step();
        wr_valid = 1'b0; events = 7'd0;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                rd_valid = 1'b1; rd_idx = 4'(k + 2); rd_tid = 9'(k);
                exp[k] = m_read(rd_idx);
            end else begin
                rd_valid = 1'b0;
            end
            step();
            if (k >= 1) begin
                chk_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd0 || exp[k-1] !== 64'd0)
                    $display("FAIL ctrl_clear_all cnt%0d: got v=%b data=%0d want 1/0", k - 1, rsp_valid, rsp_data);
                else pass_cnt++;
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp [16];
        events = 7'b1000000;
        for (int i = 0; i < 5; i++) step();
        events = 7'd0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin
                rd_valid = 1'b1; rd_idx = 4'(k); rd_tid = 9'(k);
                exp[k] = m_read(rd_idx);
            end else begin
                rd_valid = 1'b0; rd_tid = 9'd0;
            end
            step();
            if (k >= 1 && k <= 16) begin
                chk_cnt++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'(k - 1) || rsp_data !== exp[k-1])
                    $display("FAIL b2b idx%0d: got v=%b tid=%0d data=%h want 1/%0d/%h",
                             k - 1, rsp_valid, rsp_tid, rsp_data, k - 1, exp[k-1]);
                else pass_cnt++;
            end
        end
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_tail: got rsp_valid=%b want 0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [63:0] want [3];
        want[0] = 64'd254; want[1] = 64'd255; want[2] = 64'd0;
        n_events = 7'b1000000;
        for (int i = 0; i < 254; i++) step();
        n_events = 7'd0;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                n_events = 7'b1000000;
                step();
                n_events = 7'd0;
            end
            n_rd_valid = 1'b1; n_rd_idx = 4'd8; n_rd_tid = 9'(20 + r);
            step();
            n_rd_valid = 1'b0;
            step();
            chk_cnt++; if (n_rsp_valid !== 1'b1 || n_rsp_tid !== 9'(20 + r) || n_rsp_data !== want[r])
                $display("FAIL wrap step%0d: got v=%b tid=%0d data=%0d want 1/%0d/%0d",
                         r, n_rsp_valid, n_rsp_tid, n_rsp_data, 20 + r, want[r]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int   errs;
        errs = 0;
        for (int k = 0; k < 402; k++) begin
            if (k < 400) begin
                wr_valid = ($urandom_range(0, 3) == 0);
                wr_idx   = 4'($urandom_range(0, 15));
                wr_data  = {$urandom, $urandom};
                events   = 7'($urandom);
                rd_valid = ($urandom_range(0, 1) == 1);
                rd_idx   = 4'($urandom_range(0, 15));
                rd_tid   = 9'($urandom);
            end else begin
                idle_inputs();
            end
            if (rd_valid) q.push_back('{cyc + 2, rd_tid, m_read(rd_idx)});
            step();
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk_cnt++; if (rsp_valid !== 1'b1 || rsp_tid !== e.tid || rsp_data !== e.data) begin
                    $display("FAIL random_rsp cyc%0d: got v=%b tid=%h data=%h want 1/%h/%h",
                             cyc, rsp_valid, rsp_tid, rsp_data, e.tid, e.data);
                    errs++;
                end else pass_cnt++;
            end else begin
                chk_cnt++; if (rsp_valid !== 1'b0 || rsp_tid !== 9'd0 || rsp_data !== 64'd0) begin
                    $display("FAIL random_idle cyc%0d: got v=%b tid=%h data=%h want 0", cyc, rsp_valid, rsp_tid, rsp_data);
                    errs++;
                end else pass_cnt++;
            end
            chk_cnt++; if (vtp_mode !== m_mode[MODE_W-1:0] || vtp_pt_base !== m_base[BASE_W-1:0] || vtp_pt_base_valid !== m_valid) begin
                $display("FAIL random_csr cyc%0d: got %h/%h/%b want %h/%h/%b", cyc, vtp_mode, vtp_pt_base,
                         vtp_pt_base_valid, m_mode[MODE_W-1:0], m_base[BASE_W-1:0], m_valid);
                errs++;
            end else pass_cnt++;
            if (errs > 10) break;
        end
    endtask

    task automatic test_reset_inflight();
        rd_valid = 1'b1; rd_idx = 4'd1; rd_tid = 9'd33;
        step();
        rd_valid = 1'b0;
        reset = 1'b1;
        step();
        chk_cnt++; if (rsp_valid !== 1'b0 || rsp_tid !== 9'd0 || rsp_data !== 64'd0 || vtp_mode !== '0 ||
                       vtp_pt_base !== '0 || vtp_pt_base_valid !== 1'b0)
            $display("FAIL reset_inflight_outputs: got v=%b tid=%h data=%h mode=%h base=%h bv=%b want all 0",
                     rsp_valid, rsp_tid, rsp_data, vtp_mode, vtp_pt_base, vtp_pt_base_valid);
        else pass_cnt++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_inflight_drop%0d: got rsp_valid=%b want 0", i, rsp_valid); else pass_cnt++;
        end
        rd_valid = 1'b1; rd_idx = 4'd8; rd_tid = 9'd34;
        step();
        rd_valid = 1'b0;
        step();
        chk_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 64'd0)
            $display("FAIL reset_cnt_cleared: got v=%b data=%0d want 1/0", rsp_valid, rsp_data);
        else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 7; i++) m_cnt[i] = 64'd0;
        m_mode = 64'd0; m_base = 64'd0; m_valid = 1'b0;
        test_reset();
        test_csr_write();
        test_events();
        test_clear();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
